// File: rtl/sram_1rw1r_scrub.sv
// ============================================================================
// Module   : sram_1rw1r_scrub
// Purpose  : Single-clock SRAM with one read/write port and one read port,
//            plus post-reset scrub, read-valid strobes and collision flag.
//            Optional macro SRAM_BYPASS_EN: write-through on a collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_1rw1r_scrub #(
   parameter int                  DATA_WIDTH     = 32,
   parameter int                  ADDR_WIDTH     = 9,
   parameter int                  LANE_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
   parameter bit                  CLEAR_ON_RESET = 1'b1,
   localparam int                 NUM_WMASKS     = DATA_WIDTH / LANE_WIDTH,
   localparam int                 DEPTH          = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   input  logic                  cs0,
   input  logic                  we0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  valid0,
   input  logic                  cs1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  valid1,
   output logic                  collision
);

   typedef enum logic [0:0] {
      SCRUB = 1'b0,
      READY = 1'b1
   } state_t;

   localparam state_t               C_RESET_STATE = CLEAR_ON_RESET ? SCRUB : READY;
   localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_cnt;

   logic                  w_ready;
   logic                  w_scrub_we;
   logic                  w_wr0;
   logic                  w_rd0;
   logic                  w_rd1;
   logic                  w_collide;
   logic [DATA_WIDTH-1:0] w_rd1_data;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= C_RESET_STATE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == SCRUB) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_scrub_we   = 1'b0;
      case (r_state)
         SCRUB: begin
            w_scrub_we = ~rst;
            if (r_cnt == C_LAST_ADDR) begin
               w_state_next = READY;
            end
         end
         READY: begin
            w_ready = ~rst;
         end
         default: begin
            w_state_next = C_RESET_STATE;
         end
      endcase
   end

   assign busy = (r_state == SCRUB);

   // ------------------------------------------------------------------
   // Port decode
   // ------------------------------------------------------------------
   assign w_wr0     = w_ready & cs0 & we0;
   assign w_rd0     = w_ready & cs0 & ~we0;
   assign w_rd1     = w_ready & cs1;
   assign w_collide = w_wr0 & w_rd1 & (addr0 == addr1);

`ifdef SRAM_BYPASS_EN
   // Write-through: merge the enabled write lanes over the stored word.
   always_comb begin
      w_rd1_data = r_mem[addr1];
      if (w_collide) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               w_rd1_data[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end
`else
   assign w_rd1_data = r_mem[addr1];
`endif

   // ------------------------------------------------------------------
   // Storage array (contents survive reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_scrub_we) begin
         r_mem[r_cnt] <= INIT_VALUE;
      end else if (w_wr0) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               r_mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered read outputs; data holds when no read is issued
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         dout0     <= '0;
         dout1     <= '0;
         valid0    <= 1'b0;
         valid1    <= 1'b0;
         collision <= 1'b0;
      end else begin
         valid0    <= w_rd0;
         valid1    <= w_rd1;
         collision <= w_collide;
         if (w_rd0) begin
            dout0 <= r_mem[addr0];
         end
         if (w_rd1) begin
            dout1 <= w_rd1_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw1r_scrub.sv
// ============================================================================
// Module   : tb_sram_1rw1r_scrub
// Purpose  : Directed self-checking bench for sram_1rw1r_scrub (default
//            32x512, byte lanes, scrub on reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_1rw1r_scrub;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic        cs0, we0, cs1;
   logic [3:0]  wmask0;
   logic [8:0]  addr0, addr1;
   logic [31:0] din0, dout0, dout1;
   logic        valid0, valid1, collision;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_1rw1r_scrub dut (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy),
      .cs0       (cs0),
      .we0       (we0),
      .wmask0    (wmask0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0),
      .valid0    (valid0),
      .cs1       (cs1),
      .addr1     (addr1),
      .dout1     (dout1),
      .valid1    (valid1),
      .collision (collision)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs0 = 1'b0; we0 = 1'b0; wmask0 = 4'h0; addr0 = '0; din0 = '0;
      cs1 = 1'b0; addr1 = '0;
   endtask

   task automatic write0(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
      cs0 = 1'b1; we0 = 1'b1; addr0 = a; din0 = d; wmask0 = m;
      tick();
      idle();
   endtask

   // Counts busy-high samples from now until busy drops, with ports poked.
   task automatic count_scrub(output int busy_cycles, output int valid_pulses);
      int guard;
      busy_cycles  = 0;
      valid_pulses = 0;
      guard        = 0;
      cs0 = 1'b1; we0 = 1'b0; cs1 = 1'b1; addr0 = 9'h1FF; addr1 = 9'h1FF;
      while (busy === 1'b1 && guard < 2000) begin
         busy_cycles++;
         if (valid0 === 1'b1 || valid1 === 1'b1) valid_pulses++;
         tick();
         guard++;
      end
      if (guard >= 2000) check("scrub_timeout", 32'(guard), 32'd512);
      idle();
   endtask

   logic [31:0] exp_coll;
   int          bc, vp;

   initial begin
      idle();
      rst = 1'b1;
      tick(); tick(); tick();

      check("rst_dout0",     dout0,     32'h0);
      check("rst_dout1",     dout1,     32'h0);
      check("rst_valid0",    32'(valid0), 32'h0);
      check("rst_valid1",    32'(valid1), 32'h0);
      check("rst_collision", 32'(collision), 32'h0);
      check("rst_busy",      32'(busy), 32'h1);

      rst = 1'b0;
      count_scrub(bc, vp);
      check("scrub_busy_cycles", 32'(bc), 32'd512);
      check("scrub_no_valid",    32'(vp), 32'd0);
      check("scrub_dout1_hold",  dout1, 32'h0);

      // Port 1 read of the last word after scrub
      cs1 = 1'b1; addr1 = 9'h1FF;
      tick(); idle();
      check("p1_last_data",  dout1, 32'h0);
      check("p1_last_valid", 32'(valid1), 32'h1);
      tick();
      check("p1_valid_pulse", 32'(valid1), 32'h0);

      // Masked writes then port 0 read
      write0(9'h010, 32'hDEADBEEF, 4'b1111);
      check("wr_no_valid0", 32'(valid0), 32'h0);
      write0(9'h010, 32'h11223344, 4'b0101);
      write0(9'h010, 32'hFFFFFFFF, 4'b0000);
      cs0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
      tick(); idle();
      check("mask_merge_data",  dout0, 32'hDE22BE44);
      check("mask_merge_valid", 32'(valid0), 32'h1);
      tick();
      check("valid0_pulse", 32'(valid0), 32'h0);

      // Collision: full-mask write while port 1 reads the same address
      write0(9'h020, 32'h12345678, 4'b1111);
      cs0 = 1'b1; we0 = 1'b1; addr0 = 9'h020; din0 = 32'hCAFEF00D; wmask0 = 4'hF;
      cs1 = 1'b1; addr1 = 9'h020;
      tick(); idle();
`ifdef SRAM_BYPASS_EN
      exp_coll = 32'hCAFEF00D;
`else
      exp_coll = 32'h12345678;
`endif
      check("coll_flag",   32'(collision), 32'h1);
      check("coll_dout1",  dout1, exp_coll);
      check("coll_valid1", 32'(valid1), 32'h1);
      tick();
      check("coll_pulse", 32'(collision), 32'h0);
      cs1 = 1'b1; addr1 = 9'h020;
      tick(); idle();
      check("coll_after", dout1, 32'hCAFEF00D);

      // Empty-mask collision still flags, data unchanged
      cs0 = 1'b1; we0 = 1'b1; addr0 = 9'h020; din0 = 32'h0; wmask0 = 4'h0;
      cs1 = 1'b1; addr1 = 9'h020;
      tick(); idle();
      check("coll_nomask_flag", 32'(collision), 32'h1);
      check("coll_nomask_data", dout1, 32'hCAFEF00D);

      // Different addresses: no collision
      cs0 = 1'b1; we0 = 1'b1; addr0 = 9'h021; din0 = 32'h5; wmask0 = 4'hF;
      cs1 = 1'b1; addr1 = 9'h020;
      tick(); idle();
      check("no_coll_diff_addr", 32'(collision), 32'h0);

      // Hold after deselect
      write0(9'h030, 32'hAAAA5555, 4'hF);
      write0(9'h031, 32'h0F0F0F0F, 4'hF);
      cs0 = 1'b1; we0 = 1'b0; addr0 = 9'h030; cs1 = 1'b1; addr1 = 9'h031;
      tick(); idle();
      check("hold_rd0", dout0, 32'hAAAA5555);
      check("hold_rd1", dout1, 32'h0F0F0F0F);
      for (int i = 0; i < 5; i++) tick();
      check("hold_dout0",  dout0, 32'hAAAA5555);
      check("hold_dout1",  dout1, 32'h0F0F0F0F);
      check("hold_valid0", 32'(valid0), 32'h0);
      check("hold_valid1", 32'(valid1), 32'h0);

      // Both ports read the same address
      cs0 = 1'b1; we0 = 1'b0; addr0 = 9'h031; cs1 = 1'b1; addr1 = 9'h031;
      tick(); idle();
      check("same_rd0",     dout0, 32'h0F0F0F0F);
      check("same_rd1",     dout1, 32'h0F0F0F0F);
      check("same_no_coll", 32'(collision), 32'h0);

      // Back-to-back port 0 reads
      cs0 = 1'b1; we0 = 1'b0; addr0 = 9'h030;
      tick();
      check("b2b_rd_a", dout0, 32'hAAAA5555);
      addr0 = 9'h010;
      tick(); idle();
      check("b2b_rd_b",    dout0, 32'hDE22BE44);
      check("b2b_valid_b", 32'(valid0), 32'h1);

      // Reset, then reset again mid-scrub with a read request pending
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cs1 = 1'b1; addr1 = 9'h030;
      for (int i = 0; i < 100; i++) tick();
      check("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      check("mid_rst_valid1", 32'(valid1), 32'h0);
      check("mid_rst_dout1",  dout1, 32'h0);
      rst = 1'b0;
      count_scrub(bc, vp);
      check("rescrub_busy_cycles", 32'(bc), 32'd512);
      check("rescrub_no_valid",    32'(vp), 32'd0);

      // Scrub cleared previously written data
      cs0 = 1'b1; we0 = 1'b0; addr0 = 9'h010; cs1 = 1'b1; addr1 = 9'h030;
      tick(); idle();
      check("cleared_p0", dout0, 32'h0);
      check("cleared_p1", dout1, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
